// File: rtl/muldiv.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with architectural HI/LO registers and MTHI/MTLO writes.
module muldiv #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hiWe,
  input  logic         loWe,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic [1:0]   dbg_state
);

  // Handshake: start is taken at an edge where busy=0; busy stays high until the
  // edge that writes HI/LO, and done pulses for exactly the cycle after that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t state, state_next;

  logic [CW-1:0]  cnt;
  logic [1:0]     op_r;
  logic [N-1:0]   a_r;
  logic           sb_r;
  logic           bzero_r;
  logic [N-1:0]   opnd;
  logic [2*N-1:0] prod;

  logic           accept;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_shift;
  logic [N-1:0]   div_sub;
  logic           div_ge;
  logic [2*N-1:0] div_next;
  logic [2*N-1:0] prod_neg;
  logic           sgn;
  logic [N-1:0]   res_hi, res_lo;

  assign accept = start && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CNT_LAST) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Signed ops run on magnitudes; an N-bit unsigned holds |most-negative| exactly.
  always_comb begin
    a_mag = (!op[0] && a[N-1]) ? (~a + 1'b1) : a;
    b_mag = (!op[0] && b[N-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    mul_sum   = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    mul_next  = {mul_sum, prod[N-1:1]};
    div_shift = {prod[2*N-1:N], prod[N-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[N-1:0] - opnd;
    div_next  = div_ge ? {div_sub, prod[N-2:0], 1'b1}
                       : {div_shift[N-1:0], prod[N-2:0], 1'b0};
    prod_neg  = ~prod + 1'b1;
    sgn       = !op_r[0];
    res_hi    = prod[2*N-1:N];
    res_lo    = prod[N-1:0];
    if (!op_r[1]) begin
      if (sgn && (a_r[N-1] ^ sb_r)) begin
        res_hi = prod_neg[2*N-1:N];
        res_lo = prod_neg[N-1:0];
      end
    end else if (bzero_r) begin
      res_hi = a_r;
      res_lo = '1;
    end else begin
      if (sgn && (a_r[N-1] ^ sb_r)) res_lo = ~prod[N-1:0] + 1'b1;
      if (sgn && a_r[N-1])          res_hi = ~prod[2*N-1:N] + 1'b1;
    end
  end

  // prod is {remainder, quotient} for divide and {partial product, multiplier} for multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      op_r    <= '0;
      a_r     <= '0;
      sb_r    <= 1'b0;
      bzero_r <= 1'b0;
      opnd    <= '0;
      prod    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hiWe) hi <= wdata;
          if (loWe) lo <= wdata;
          if (accept) begin
            cnt     <= '0;
            op_r    <= op;
            a_r     <= a;
            sb_r    <= b[N-1];
            bzero_r <= (b == '0);
            opnd    <= op[1] ? b_mag : a_mag;
            prod    <= {{N{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        RUN: begin
          cnt  <= cnt + 1'b1;
          prod <= op_r[1] ? div_next : mul_next;
        end
        FIN: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Randomized scoreboard bench for muldiv: driver pushes reference results,
// a done-triggered monitor pops and compares HI, LO and latency.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hiWe = 1'b0, loWe = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  logic [31:0] exp_cyc_q[$];
  logic [31:0] mdl_hi = '0, mdl_lo = '0;

  muldiv #(.N(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hiWe(hiWe), .loWe(loWe), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model from the architectural definition using wide integer arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] h, output logic [31:0] l);
    longint      ps;
    logic [63:0] pu;
    int          sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    h = '0;
    l = '0;
    case (o)
      2'd0: begin ps = longint'(sx) * longint'(sy); pu = ps; h = pu[63:32]; l = pu[31:0]; end
      2'd1: begin pu = {32'd0, x} * {32'd0, y}; h = pu[63:32]; l = pu[31:0]; end
      2'd2: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
        else begin l = sx / sy; h = sx % sy; end
      end
      default: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin l = x / y; h = x % y; end
      end
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    logic [31:0] h, l;
    wait_idle();
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (push) begin
      ref_model(o, x, y, h, l);
      exp_hi_q.push_back(h);
      exp_lo_q.push_back(l);
      exp_cyc_q.push_back(cyc + 33);
      mdl_hi = h;
      mdl_lo = l;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_hi_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_hi_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", exp_hi_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_hi_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 hi=%h lo=%h", hi, lo);
      end else begin
        chk("hi_result", hi, exp_hi_q.pop_front());
        chk("lo_result", lo, exp_lo_q.pop_front());
        chk("latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] prev_hi;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);

    // Directed corner cases; consecutive issues also exercise start in the done cycle.
    issue(2'd0, 32'hFFFF_FFFF, 32'h2, 1'b1);
    issue(2'd1, 32'hFFFF_FFFF, 32'h2, 1'b1);
    issue(2'd2, 32'hFFFF_FFF9, 32'h2, 1'b1);
    issue(2'd3, 32'h7, 32'h2, 1'b1);
    issue(2'd3, 32'h7, 32'h0, 1'b1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'd2, 32'hFFFF_FFF9, 32'h0, 1'b1);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    drain();

    // A start while busy is dropped; an MTHI while busy is ignored.
    prev_hi = mdl_hi;
    issue(2'd1, 32'd3, 32'd5, 1'b1);
    hiWe = 1'b1; wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    hiWe = 1'b0;
    chk("mthi_while_busy", hi, prev_hi);
    repeat (7) @(posedge clk);
    #1 start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    drain();
    repeat (5) @(posedge clk);
    #1;

    hiWe = 1'b1; loWe = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hiWe = 1'b0; loWe = 1'b0;
    chk("mthi_idle", hi, 32'h1234_5678);
    chk("mtlo_idle", lo, 32'h1234_5678);

    // Abort mid-operation: no partial result and no done pulse.
    issue(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (13) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(2'd1, 32'd6, 32'd7, 1'b1);
    drain();

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      issue(ro, ra, rb, 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit for the MIPS execute stage, sitting beside `alu` and consuming the same two register operands. It executes MULT, MULTU, DIV and DIVU over N+1 cycles and holds the results in architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. The hazard unit stalls the pipeline on `busy`.

## Interface
- `N`, 32: operand, HI and LO width; must be at least 4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a new operation; accepted only when `busy`=0.
- `op` in 2: operation select. 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `a` in N: first operand. Multiplicand for multiply, dividend for divide.
- `b` in N: second operand. Multiplier for multiply, divisor for divide.
- `hiWe` in 1: MTHI write enable; ignored while `busy`=1.
- `loWe` in 1: MTLO write enable; ignored while `busy`=1.
- `wdata` in N: MTHI/MTLO write data.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; new HI/LO values are visible in this cycle.
- `hi` out N: HI register. Holds the product upper half, or the remainder.
- `lo` out N: LO register. Holds the product lower half, or the quotient.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; an N-iteration counter runs.
  - FIN: `busy`=1; sign correction is applied and the result is written to HI/LO.
- Transitions: IDLE→RUN on `start`. RUN→FIN when the counter reaches N-1. FIN→IDLE always.
- On accept, `a`, `b` and `op` are latched. Later input changes have no effect.
- Signed ops (MULT, DIV) work on magnitudes (two's-complement absolute value, N+1-bit safe). The signs are recorded for the FIN correction.
- Multiply:
  - Shift-add algorithm, 1 bit per RUN cycle, using a 2N-bit product register.
  - Result: HI = product[2N-1:N], LO = product[N-1:0].
  - MULT result is negated when the operand signs differ.
- Divide:
  - Restoring algorithm, 1 quotient bit per RUN cycle.
  - Signed: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Divisor 0, any op: LO = all ones, HI = `a` unchanged. No exception is raised.
  - DIV with `a`=most-negative and `b`=-1: LO = most-negative, HI = 0.
- MTHI/MTLO:
  - When `busy`=0 and `hiWe`/`loWe`=1, HI/LO ← `wdata` at the edge.
  - If `start` is accepted at the same edge, the write still happens; the operation result later overwrites it.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0; state IDLE; counter 0.
- `start` is sampled at edge E0. `busy`=1 after E0.
- RUN covers edges E1..EN.
- At edge EN+1: HI/LO are written, `busy`=0, `done`=1.
- `done` drops after EN+2 unless it is re-asserted.
- Latency from accept to result is N+1 cycles (33 for N=32).
- Back-to-back: a `start` in the `done` cycle is accepted, since `busy`=0 then.
- `reset` mid-operation aborts the operation at the next edge: HI=LO=0, `busy`=0, `done`=0. No partial result is written.
- `hi`/`lo` hold their values outside result writes, MTHI/MTLO writes and reset.

## Test plan
- MULT `a`=0xFFFFFFFF, `b`=0x00000002 → `done` 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV `a`=0xFFFFFFF9 (-7), `b`=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU `a`=7, `b`=2 → LO=3, HI=1.
- DIVU `a`=7, `b`=0 → LO=0xFFFFFFFF, HI=7. DIV `a`=0x80000000, `b`=0xFFFFFFFF → LO=0x80000000, HI=0.
- Start MULTU 3×5, then pulse `start` with DIV 9/3 at cycle 10 → the second start is ignored; HI=0, LO=15. A `start` in the `done` cycle is accepted and `busy` is 1 the next cycle.
- While `busy`=1, `hiWe`=1 with `wdata`=0xAAAA5555 → HI is unaffected. When idle, `hiWe`=1 and `loWe`=1 with 0x12345678 → both registers read 0x12345678 the next cycle.
- `reset` at cycle 15 of a MULTU → next cycle `busy`=0 and HI=LO=0; `done` never pulses. A new op started afterwards completes correctly.
